// File: rtl/wb_decoder.sv
// Wishbone single-master to N-slave decoder: registered slave select, ack/err/data routed back.
// Latency: 2-cycle minimum transfer (decode cycle + access cycle); unmapped addresses err on cycle 2.
// Backpressure: the master waits on the slave ack; WB_DECODER_TIMEOUT_EN adds an abort-on-stall counter.
module wb_decoder #(
  parameter int                N          = 2,
  parameter int                AW         = 32,
  parameter int                DW         = 32,
  parameter logic [N*AW-1:0]   SLAVE_BASE = '0,
  parameter logic [N*AW-1:0]   SLAVE_MASK = '0,
  parameter int                TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m_cyc_i,
  input  logic              m_stb_i,
  input  logic              m_we_i,
  input  logic [AW-1:0]     m_adr_i,
  input  logic [DW-1:0]     m_dat_i,
  input  logic [DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]     m_dat_o,
  output logic              m_ack_o,
  output logic              m_err_o,
  output logic [N-1:0]      s_cyc_o,
  output logic [N-1:0]      s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [N*DW-1:0]   s_dat_i,
  input  logic [N-1:0]      s_ack_i,
  input  logic [N-1:0]      s_err_i
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_decoder: TIMEOUT must be in 1..65535");
  end
  if (DW % 8 != 0) begin : g_bad_dw
    $error("wb_decoder: DW must be a multiple of 8");
  end

`ifdef WB_DECODER_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERROR, ST_TIMEOUT} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_r;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERROR} state_t;
`endif

  state_t          state_r, state_n;
  logic [N-1:0]    sel_r, sel_n;
  logic [N-1:0]    match_oh;
  logic [DW-1:0]   rd_dat;
  logic            sel_ack, sel_err;

  assign s_we_o  = m_we_i;
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;

  // Scan from the top so the lowest matching index is written last and wins.
  always_comb begin
    match_oh = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((m_adr_i & SLAVE_MASK[k*AW +: AW]) == (SLAVE_BASE[k*AW +: AW] & SLAVE_MASK[k*AW +: AW])) begin
        match_oh    = '0;
        match_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_r[k]) rd_dat = rd_dat | s_dat_i[k*DW +: DW];
    end
  end

  assign sel_ack = |(s_ack_i & sel_r);
  assign sel_err = |(s_err_i & sel_r);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      sel_r   <= '0;
    end else begin
      state_r <= state_n;
      sel_r   <= sel_n;
    end
  end

`ifdef WB_DECODER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (state_r == ST_IDLE && state_n == ST_ACCESS) begin
      cnt_r <= '0;
    end else if (state_r == ST_ACCESS && !(sel_ack || sel_err)) begin
      cnt_r <= cnt_r + 16'd1;
    end
  end
`endif

  always_comb begin
    state_n = state_r;
    sel_n   = sel_r;
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    case (state_r)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (|match_oh) begin
            sel_n   = match_oh;
            state_n = ST_ACCESS;
          end else begin
            state_n = ST_ERROR;
          end
        end
      end
      ST_ACCESS: begin
        s_cyc_o = sel_r & {N{m_cyc_i}};
        s_stb_o = sel_r & {N{m_stb_i}};
        m_ack_o = sel_ack;
        m_err_o = sel_err;
        m_dat_o = rd_dat;
        // A response in the same cycle as a master abort is still forwarded.
        if (sel_ack || sel_err || !m_cyc_i) begin
          state_n = ST_IDLE;
          sel_n   = '0;
        end
`ifdef WB_DECODER_TIMEOUT_EN
        else if (cnt_r == TO_LAST) begin
          state_n = ST_TIMEOUT;
          sel_n   = '0;
        end
`endif
      end
      ST_ERROR: begin
        m_err_o = m_cyc_i;
        state_n = ST_IDLE;
      end
`ifdef WB_DECODER_TIMEOUT_EN
      ST_TIMEOUT: begin
        m_err_o = m_cyc_i;
        state_n = ST_IDLE;
      end
`endif
      default: begin
        state_n = ST_IDLE;
        sel_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_decoder.sv
// Directed scoreboard bench for wb_decoder: stimulus queues expected responses, a negedge monitor checks them.
module tb_wb_decoder;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic [31:0] m_adr_i = '0, m_dat_i = '0;
  logic [3:0]  m_sel_i = '0;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o;
  logic [1:0]  s_cyc_o, s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [63:0] s_dat_i;
  logic [1:0]  s_ack_i, s_err_i;

  // Bench slave models: respond lat cycles after first seeing a strobe (8'hFF = never).
  logic [7:0]  lat0 = 8'hFF, lat1 = 8'hFF, wcnt0 = '0, wcnt1 = '0;
  logic        err0 = 1'b0, err1 = 1'b0, spur1 = 1'b0, hit0, hit1;
  logic [31:0] rdat0 = '0, rdat1 = '0;

  typedef struct {
    logic        ack;
    logic [31:0] dat;
    logic [1:0]  stb;
    int          lat;
    logic        we;
    logic [31:0] wdat;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;

  wb_decoder #(
    .N(2), .AW(32), .DW(32),
    .SLAVE_BASE({32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk_i = ~clk_i;

  assign hit0    = s_cyc_o[0] & s_stb_o[0] & (lat0 != 8'hFF) & (wcnt0 == lat0);
  assign hit1    = s_cyc_o[1] & s_stb_o[1] & (lat1 != 8'hFF) & (wcnt1 == lat1);
  assign s_ack_i = {(hit1 & ~err1) | spur1, hit0 & ~err0};
  assign s_err_i = {hit1 & err1, hit0 & err0};
  assign s_dat_i = {rdat1, rdat0};

  always @(posedge clk_i) begin
    wcnt0 <= (s_cyc_o[0] && s_stb_o[0] && !hit0 && !rst_i) ? wcnt0 + 8'd1 : 8'd0;
    wcnt1 <= (s_cyc_o[1] && s_stb_o[1] && !hit1 && !rst_i) ? wcnt1 + 8'd1 : 8'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: lat counts strobed master cycles up to and including the response cycle.
  logic [1:0] stb_seen = '0;
  int         ccnt = 0;
  exp_t       e;
  always @(negedge clk_i) begin
    if (!m_cyc_i) begin
      stb_seen = '0;
      ccnt     = 0;
      check("gated_s_cyc", {30'd0, s_cyc_o}, 32'd0);
      check("gated_s_stb", {30'd0, s_stb_o}, 32'd0);
    end else begin
      if (m_stb_i) ccnt++;
      stb_seen = stb_seen | s_stb_o;
    end
    if (m_ack_o || m_err_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got ack=%b err=%b, required no response", m_ack_o, m_err_o);
      end else begin
        e = exp_q.pop_front();
        check("rsp_ack", {31'd0, m_ack_o}, {31'd0, e.ack});
        check("rsp_err", {31'd0, m_err_o}, {31'd0, ~e.ack});
        check("rsp_stb", {30'd0, stb_seen}, {30'd0, e.stb});
        check("rsp_lat", ccnt, e.lat);
        if (e.ack && !e.we) check("rd_dat", m_dat_o, e.dat);
        if (e.we) begin
          check("s_we", {31'd0, s_we_o}, 32'd1);
          check("s_dat", s_dat_o, e.wdat);
        end
      end
    end
  end

  task automatic expect_rsp(input logic ack, input logic [31:0] dat, input logic [1:0] stb,
                            input int lat, input logic we, input logic [31:0] wdat);
    exp_t x;
    x.ack = ack; x.dat = dat; x.stb = stb; x.lat = lat; x.we = we; x.wdat = wdat;
    exp_q.push_back(x);
  endtask

  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    logic got;
    m_we_i = we; m_adr_i = adr; m_dat_i = dat; m_sel_i = 4'hF;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_i);
      got = m_ack_o | m_err_o;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: no response for adr %h, required ack or err", adr);
    end
    @(posedge clk_i); #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_ack"}, {31'd0, m_ack_o}, 32'd0);
    check({tag, "_m_err"}, {31'd0, m_err_o}, 32'd0);
    check({tag, "_s_cyc"}, {30'd0, s_cyc_o}, 32'd0);
    check({tag, "_s_stb"}, {30'd0, s_stb_o}, 32'd0);
    check({tag, "_m_dat"}, m_dat_o, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;

    // Read slave1, acks one cycle after its strobe.
    lat1 = 8'd1; rdat1 = 32'hDEAD_BEEF;
    expect_rsp(1'b1, 32'hDEAD_BEEF, 2'b10, 3, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_1004, 32'd0);

    // Write slave0, immediate ack, spurious slave1 ack held high throughout.
    lat0 = 8'd0; spur1 = 1'b1;
    expect_rsp(1'b1, 32'd0, 2'b01, 2, 1'b1, 32'h1234_5678);
    do_req(1'b1, 32'h0000_0010, 32'h1234_5678);

    // Slower slave0 write: the spurious slave1 ack must not end it early.
    lat0 = 8'd2;
    expect_rsp(1'b1, 32'd0, 2'b01, 4, 1'b1, 32'hCAFE_F00D);
    do_req(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D);
    spur1 = 1'b0;

    // Unmapped address: err on the second cycle, no slave strobed.
    expect_rsp(1'b0, 32'd0, 2'b00, 2, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_2000, 32'd0);

    // Slave0 error response is routed back.
    lat0 = 8'd1; err0 = 1'b1;
    expect_rsp(1'b0, 32'd0, 2'b01, 3, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_0008, 32'd0);
    err0 = 1'b0;

    // Master aborts on the third access cycle.
    lat1 = 8'hFF;
    m_we_i = 1'b0; m_adr_i = 32'h0000_1000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 m_cyc_i = 1'b0; m_stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    lat0 = 8'd0; rdat0 = 32'hA5A5_5A5A;
    expect_rsp(1'b1, 32'hA5A5_5A5A, 2'b01, 2, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_0100, 32'd0);

    // Reset during access; a later slave1 ack must not be forwarded.
    lat1 = 8'd6;
    m_adr_i = 32'h0000_1000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0; spur1 = 1'b1;
    @(negedge clk_i);
    check_all_zero("post_rst");
    repeat (3) @(posedge clk_i);
    #1 spur1 = 1'b0;
    lat1 = 8'd0; rdat1 = 32'h0BAD_CAFE;
    expect_rsp(1'b1, 32'h0BAD_CAFE, 2'b10, 2, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_1FF0, 32'd0);

`ifdef WB_DECODER_TIMEOUT_EN
    // Stalled slave1: 8 access cycles, then err; slave0 still works afterwards.
    lat1 = 8'hFF;
    expect_rsp(1'b0, 32'd0, 2'b10, 10, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_1000, 32'd0);
    lat0 = 8'd0; rdat0 = 32'h1111_2222;
    expect_rsp(1'b1, 32'h1111_2222, 2'b01, 2, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_0004, 32'd0);
    // Ack on the 8th access cycle wins over the timeout.
    lat1 = 8'd7; rdat1 = 32'h7777_8888;
    expect_rsp(1'b1, 32'h7777_8888, 2'b10, 9, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_1008, 32'd0);
`else
    // Without the timeout a slow slave is simply waited for.
    lat1 = 8'd20; rdat1 = 32'h7777_8888;
    expect_rsp(1'b1, 32'h7777_8888, 2'b10, 22, 1'b0, 32'd0);
    do_req(1'b0, 32'h0000_1008, 32'd0);
`endif

    repeat (3) @(posedge clk_i);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_decoder.md
Name: wb_decoder

Overview:
Wishbone single-master to N-slave address decoder and response router. It is the slave-facing counterpart to the multi-master arbiter: it sits between the arbitrated common master bus and the peripheral slaves. It registers the slave selection, forwards the cycle to exactly one slave and routes ack/err/data back. Unmapped addresses and stalled slaves are terminated with an error response.

Parameters:
N, 2, number of slaves
AW, 32, address width
DW, 32, data width (multiple of 8)
SLAVE_BASE, 0, packed N*AW base addresses; slave k occupies bits [k*AW +: AW]
SLAVE_MASK, 0, packed N*AW masks; slave k matches when (m_adr_i & mask_k) == (base_k & mask_k)
TIMEOUT, 255, ACCESS cycles without ack/err before abort (1..2^16-1); used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_we_i  in  1  write enable
m_adr_i  in  AW  address
m_dat_i  in  DW  write data
m_sel_i  in  DW/8  byte selects
m_dat_o  out  DW  read data
m_ack_o  out  1  acknowledge
m_err_o  out  1  error
s_cyc_o  out  N  per-slave cycle
s_stb_o  out  N  per-slave strobe
s_we_o  out  1  shared write enable
s_adr_o  out  AW  shared address
s_dat_o  out  DW  shared write data
s_sel_o  out  DW/8  shared byte selects
s_dat_i  in  N*DW  packed slave read data
s_ack_i  in  N  slave acks
s_err_i  in  N  slave errors

Behaviour:
- One clock (clk_i); reset synchronous, active-high (rst_i). Reset -> state IDLE, sel_r=0, counter=0. All outputs 0 (s_we_o/s_adr_o/s_dat_o/s_sel_o pass-through, don't-care).
- Shared s_we_o/s_adr_o/s_dat_o/s_sel_o = master inputs, combinational pass-through.
- FSM states: IDLE, ACCESS, ERROR, TIMEOUT.
- IDLE: s_cyc_o=s_stb_o=0, m_ack_o=m_err_o=0. On m_cyc_i & m_stb_i: compute match vector. Overlapping matches: lowest index wins. Any match -> sel_r <= one-hot, go ACCESS. No match -> go ERROR.
- ACCESS: s_cyc_o = sel_r & {N{m_cyc_i}}, s_stb_o = sel_r & {N{m_stb_i}}. m_ack_o = |(s_ack_i & sel_r), m_err_o = |(s_err_i & sel_r), m_dat_o = selected slice of s_dat_i, all combinational. Acks/errs from unselected slaves are ignored.
  - Ack or err from the selected slave -> IDLE next edge, sel_r cleared. Minimum transfer is 2 cycles; the next strobe is re-decoded.
  - m_cyc_i low -> abort: s_cyc_o low in the same cycle (gated), IDLE next edge, no master response.
  - Ack and m_cyc_i drop in the same cycle: ack is forwarded, then IDLE.
- ERROR: m_err_o=1 (registered state output) for exactly one cycle if m_cyc_i is still high, else 0. No s_cyc_o. Then IDLE.
- TIMEOUT: s_cyc_o=s_stb_o=0, m_err_o=1 for one cycle (gated by m_cyc_i), then IDLE.
- m_dat_o=0 outside ACCESS.
- Reset mid-operation: the next edge forces IDLE and outputs go 0; no response is owed.

Optional Feature:
WB_DECODER_TIMEOUT_EN
- Defined: 16-bit counter cleared on IDLE->ACCESS, incremented each ACCESS cycle without ack/err. When counter == TIMEOUT-1 with no ack/err -> TIMEOUT state. Ack in the same cycle takes priority.
- Undefined: no counter and no TIMEOUT state. ACCESS waits indefinitely; TIMEOUT is ignored.

Test Plan:
Common config: N=2, base0=0x00000000 mask0=0xFFFFF000, base1=0x00001000 mask1=0xFFFFF000.
- Read 0x00001004, slave1 acks 1 cycle after stb with 0xDEADBEEF -> s_stb_o=2'b10 from the cycle after request; m_ack_o coincident with s_ack_i[1]; m_dat_o=0xDEADBEEF; s_stb_o=0 the cycle after ack.
- Write 0x00000010 data 0x12345678 sel 4'hF, slave0 acks immediately -> s_stb_o=2'b01, s_we_o=1, s_dat_o=0x12345678; transfer completes in 2 cycles; spurious s_ack_i[1] during the transfer is ignored.
- Access unmapped 0x00002000 -> s_cyc_o stays 2'b00; m_err_o high exactly one cycle, on the 2nd cycle of the request.
- WB_DECODER_TIMEOUT_EN defined, TIMEOUT=8, slave1 never acks -> after 8 ACCESS cycles s_cyc_o drops and m_err_o pulses for 1 cycle; next request to slave0 completes normally. Ack on the 8th cycle -> m_ack_o, no m_err_o.
- Master drops m_cyc_i on the 3rd ACCESS cycle -> s_cyc_o=0 same cycle; no m_ack_o/m_err_o; next request decodes normally.
- rst_i asserted 1 cycle during ACCESS -> all outputs 0 after the next edge; a later slave ack is not forwarded.
